// File: rtl/gt_2b_pkg.sv
// Shared types for the 2-bit unsigned magnitude comparator.
package gt2b_pkg;
  localparam int GT2B_W = 2;

  typedef logic [GT2B_W-1:0] gt2b_opnd_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } gt2b_res_t;
endpackage

// File: rtl/gt_2b_if.sv
// Operand/result bundle for gt_2b; master drives operands, slave is the comparator.
interface gt_2b_if;
  import gt2b_pkg::*;

  gt2b_opnd_t a;
  gt2b_opnd_t b;
  logic       in_valid;
  logic       gt;
  logic       gt_q;
  logic       eq_q;
  logic       lt_q;
  logic       out_valid;

  modport master (output a, b, in_valid, input gt, gt_q, eq_q, lt_q, out_valid);
  modport slave  (input a, b, in_valid, output gt, gt_q, eq_q, lt_q, out_valid);
endinterface

// File: rtl/gt_2b_bit_slice.sv
// One bit of a MSB-first magnitude compare; the lower-order result ripples in.
module gt_bit_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic gt_i,
  input  logic eq_i,
  output logic gt_o,
  output logic eq_o
);
  logic bit_eq;

  assign bit_eq = a_i ~^ b_i;
  // A decisive difference at this bit overrides whatever the lower bits said.
  assign gt_o   = (a_i & ~b_i) | (bit_eq & gt_i);
  assign eq_o   = bit_eq & eq_i;
endmodule

// File: rtl/gt_2b.sv
// 2-bit unsigned comparator: combinational gt plus registered gt/eq/lt.
// Optional saturating gt event counter enabled by GT2B_STATS_EN.
module gt_2b
  import gt2b_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  gt_2b_if.slave           bus
`ifdef GT2B_STATS_EN
  ,
  output logic [CNT_W-1:0] gt_count
`endif
);
  logic [GT2B_W:0] gt_c;
  logic [GT2B_W:0] eq_c;
  gt2b_res_t       res;
  gt2b_res_t       res_d, res_q;
  logic            vld_q;

  // LSB slice starts from "equal so far"; each higher slice refines the verdict.
  assign gt_c[0] = 1'b0;
  assign eq_c[0] = 1'b1;

  for (genvar i = 0; i < GT2B_W; i++) begin : g_slice
    gt_bit_slice u_slice (
      .a_i  (bus.a[i]),
      .b_i  (bus.b[i]),
      .gt_i (gt_c[i]),
      .eq_i (eq_c[i]),
      .gt_o (gt_c[i+1]),
      .eq_o (eq_c[i+1])
    );
  end

  always_comb begin
    res.gt = gt_c[GT2B_W];
    res.eq = eq_c[GT2B_W];
    res.lt = ~res.gt & ~res.eq;
  end

  always_comb begin
    res_d = res_q;
    if (bus.in_valid) res_d = res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= bus.in_valid;
    end
  end

  assign bus.gt        = res.gt;
  assign bus.gt_q      = res_q.gt;
  assign bus.eq_q      = res_q.eq;
  assign bus.lt_q      = res_q.lt;
  assign bus.out_valid = vld_q;

`ifdef GT2B_STATS_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Saturate rather than wrap so a long run never reads as a small count.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_valid && res.gt && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign gt_count = cnt_q;
`endif
endmodule

// File: tb/tb_gt_2b.sv
// Directed bench for gt_2b: exhaustive gt sweep, registered path, hold, reset, counter.
module tb_gt_2b;
  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  gt_2b_if u_if ();
  gt_2b_if u_if2 ();

  assign u_if2.a        = u_if.a;
  assign u_if2.b        = u_if.b;
  assign u_if2.in_valid = u_if.in_valid;

`ifdef GT2B_STATS_EN
  logic [15:0] gt_count;
  logic [1:0]  gt_count_sat;
`endif

  gt_2b #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (u_if.slave)
`ifdef GT2B_STATS_EN
    ,
    .gt_count (gt_count)
`endif
  );

  gt_2b #(.CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (u_if2.slave)
`ifdef GT2B_STATS_EN
    ,
    .gt_count (gt_count_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [2:0] flags, input logic ov);
    chk({tag, " flags"}, {29'd0, u_if.gt_q, u_if.eq_q, u_if.lt_q}, {29'd0, flags});
    chk({tag, " out_valid"}, {31'd0, u_if.out_valid}, {31'd0, ov});
  endtask

  initial begin
    logic [15:0] gt_tab;
    errs   = 0;
    checks = 0;
    // Bit index a*4+b set for (1,0),(2,0),(2,1),(3,0),(3,1),(3,2)
    gt_tab = 16'h7310;

    rst_n      = 1'b0;
    u_if.a     = 2'd0;
    u_if.b     = 2'd0;
    u_if.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 3'b000, 1'b0);
`ifdef GT2B_STATS_EN
    chk("reset count", {16'd0, gt_count}, 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        u_if.a = 2'(ia);
        u_if.b = 2'(ib);
        #20;
        chk($sformatf("sweep gt a=%0d b=%0d", ia, ib), {31'd0, u_if.gt}, {31'd0, gt_tab[ia*4+ib]});
      end
    end
    chk_regs("idle after sweep", 3'b000, 1'b0);

    @(negedge clk);
    u_if.a = 2'd3; u_if.b = 2'd1; u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    chk_regs("reg 3>1", 3'b100, 1'b1);
    @(negedge clk);
    u_if.a = 2'd2; u_if.b = 2'd2;
    @(posedge clk); #1;
    chk_regs("reg 2=2", 3'b010, 1'b1);
    @(negedge clk);
    u_if.a = 2'd0; u_if.b = 2'd1;
    @(posedge clk); #1;
    chk_regs("reg 0<1", 3'b001, 1'b1);

    @(negedge clk);
    u_if.a = 2'd2; u_if.b = 2'd1;
    @(posedge clk); #1;
    chk_regs("hold load", 3'b100, 1'b1);
    @(negedge clk);
    u_if.a = 2'd0; u_if.b = 2'd3; u_if.in_valid = 1'b0;
    @(posedge clk); #1;
    chk_regs("hold", 3'b100, 1'b0);
    chk("hold comb gt", {31'd0, u_if.gt}, 32'd0);

    @(negedge clk);
    rst_n = 1'b0;
    u_if.a = 2'd3; u_if.b = 2'd0; u_if.in_valid = 1'b1;
    #1;
    chk("comb gt in reset", {31'd0, u_if.gt}, 32'd1);
    @(posedge clk); #1;
    chk_regs("mid reset", 3'b000, 1'b0);
    chk("comb gt after reset edge", {31'd0, u_if.gt}, 32'd1);

`ifdef GT2B_STATS_EN
    chk("count cleared", {16'd0, gt_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    u_if.a = 2'd0; u_if.b = 2'd0;
    repeat (3) @(negedge clk);
    u_if.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("gt_count", {16'd0, gt_count}, 32'd5);
    chk("gt_count saturated", {30'd0, gt_count_sat}, 32'd3);
    chk_regs("stats last", 3'b010, 1'b0);
`else
    @(negedge clk);
    rst_n = 1'b1;
    u_if.in_valid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
